// File: rtl/rr_decode_arbiter_2.sv
// Two-requester round-robin arbiter with a bounded hold time. The 1-bit grant
// index is decoded to a one-hot grant bus; every output comes straight from a flop.
module rr_decode_arbiter_2 #(
  parameter int MAX_HOLD = 4,
  parameter int CNT_W    = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  output logic [1:0] gnt,
  output logic       gnt_idx,
  output logic       gnt_valid,
  output logic       preempt
);

  // Handshake: req[k] is a level request sampled on every rising edge and is
  // never latched. gnt/gnt_valid appear one edge later and stay up while the
  // holder keeps req high, until the hold limit hands the grant to the other side.

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(MAX_HOLD - 1);

  state_e           state_q;
  logic [1:0]       gnt_q;
  logic             idx_q;
  logic             valid_q;
  logic             preempt_q;
  logic [CNT_W-1:0] hold_cnt_q;
  logic             last_q;

  logic pick_any;
  logic pick_idx;
  logic holder_req;
  logic other_req;
  logic other_idx;

  function automatic logic [1:0] dec(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

  // On a tie, the requester that did not win last time takes the grant.
  always_comb begin
    pick_any   = |req;
    pick_idx   = (req == 2'b11) ? ~last_q : req[1];
    other_idx  = ~idx_q;
    holder_req = req[idx_q];
    other_req  = req[other_idx];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      gnt_q      <= 2'b00;
      idx_q      <= 1'b0;
      valid_q    <= 1'b0;
      preempt_q  <= 1'b0;
      hold_cnt_q <= '0;
      last_q     <= 1'b1;
    end else begin
      preempt_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (pick_any) begin
            state_q    <= GRANT;
            idx_q      <= pick_idx;
            gnt_q      <= dec(pick_idx);
            valid_q    <= 1'b1;
            last_q     <= pick_idx;
            hold_cnt_q <= '0;
          end
        end
        GRANT: begin
          if (!holder_req && other_req) begin
            idx_q      <= other_idx;
            gnt_q      <= dec(other_idx);
            last_q     <= other_idx;
            hold_cnt_q <= '0;
          end else if (!holder_req) begin
            state_q    <= IDLE;
            gnt_q      <= 2'b00;
            valid_q    <= 1'b0;
            hold_cnt_q <= '0;
          end else if (other_req && hold_cnt_q == HOLD_LIM) begin
            idx_q      <= other_idx;
            gnt_q      <= dec(other_idx);
            last_q     <= other_idx;
            hold_cnt_q <= '0;
            preempt_q  <= 1'b1;
          end else if (other_req) begin
            if (hold_cnt_q < HOLD_LIM) hold_cnt_q <= hold_cnt_q + 1'b1;
          end else begin
            // A lone holder keeps the grant indefinitely.
            hold_cnt_q <= '0;
          end
        end
        default: begin
          state_q <= IDLE;
          gnt_q   <= 2'b00;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign gnt       = gnt_q;
  assign gnt_idx   = idx_q;
  assign gnt_valid = valid_q;
  assign preempt   = preempt_q;

endmodule

// File: tb/tb_rr_decode_arbiter_2.sv
// Directed bench for rr_decode_arbiter_2 (MAX_HOLD=4). The observed word is
// {gnt, gnt_idx, gnt_valid, preempt}, sampled 1 ns after each rising edge.
module tb_rr_decode_arbiter_2;

  logic       clk;
  logic       rst_n;
  logic [1:0] req;
  logic [1:0] gnt;
  logic       gnt_idx;
  logic       gnt_valid;
  logic       preempt;

  int n_vec;
  int n_err;

  rr_decode_arbiter_2 #(.MAX_HOLD(4), .CNT_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid),
    .preempt   (preempt)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [4:0] act, input logic [4:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b, expected %b at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [4:0] obs();
    return {gnt, gnt_idx, gnt_valid, preempt};
  endfunction

  // Driver: apply req, clock once, then check outputs and the one-hot invariant.
  task automatic cyc(input logic [1:0] r, input logic [4:0] e, input string tag);
    req = r;
    @(posedge clk);
    #1;
    check(tag, obs(), e);
    check("onehot", {4'b0, &gnt}, 5'b0);
  endtask

  // Asynchronous reset pulse placed away from any rising edge.
  task automatic async_reset(input string tag);
    #2 rst_n = 1'b0;
    #1 check(tag, obs(), 5'b00_0_0_0);
    #1 rst_n = 1'b1;
  endtask

  localparam logic [4:0] IDLE0 = 5'b00_0_0_0;
  localparam logic [4:0] IDLE1 = 5'b00_1_0_0;
  localparam logic [4:0] G0    = 5'b01_0_1_0;
  localparam logic [4:0] G1    = 5'b10_1_1_0;
  localparam logic [4:0] G0P   = 5'b01_0_1_1;
  localparam logic [4:0] G1P   = 5'b10_1_1_1;

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    req   = 2'b00;
    repeat (2) @(posedge clk);
    #1 check("reset", obs(), IDLE0);
    #2 rst_n = 1'b1;

    // Idle with no requests, then an async pulse with no edge in between
    for (int i = 0; i < 5; i++) cyc(2'b00, IDLE0, "idle");
    async_reset("idle_async_rst");

    // Lone requester 0 holds indefinitely, then releases
    for (int i = 0; i < 10; i++) cyc(2'b01, G0, "lone0");
    cyc(2'b00, IDLE0, "lone0_release");

    // Contention from reset: 4-cycle holds, preempt on each switch
    async_reset("pre_contention_rst");
    for (int c = 1; c <= 16; c++) begin
      logic h;
      logic p;
      h = 1'(((c - 1) / 4) % 2);
      p = (c > 4) && ((c - 1) % 4 == 0);
      cyc(2'b11, {h ? 2'b10 : 2'b01, h, 1'b1, p}, "contention");
    end
    cyc(2'b00, IDLE1, "contention_release");

    // Direct handoff 01 -> 10 with no dead cycle
    cyc(2'b01, G0, "handoff_a");
    cyc(2'b10, G1, "handoff_b");
    cyc(2'b00, IDLE1, "handoff_release");

    // Tie fairness after each requester was last
    cyc(2'b10, G1, "tie_prep1");
    cyc(2'b00, IDLE1, "tie_idle1");
    cyc(2'b11, G0, "tie_after1");
    cyc(2'b00, IDLE0, "tie_idle0");
    cyc(2'b01, G0, "tie_prep0");
    cyc(2'b00, IDLE0, "tie_idle0b");
    cyc(2'b11, G1, "tie_after0");

    // Reset mid-grant with hold count at 2, then a fresh hold window
    cyc(2'b11, G1, "hold1");
    cyc(2'b11, G1, "hold2");
    async_reset("midgrant_rst");
    for (int i = 0; i < 4; i++) cyc(2'b11, G0, "post_rst_hold");
    cyc(2'b11, G1P, "post_rst_preempt");
    cyc(2'b11, G1, "post_rst_after");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Keep the unused constant referenced by the contention loop's expectations.
  initial if (G0P == 5'b0) $display("unreachable");

endmodule
